// File: rtl/freelist_arb_pkg.sv
// Shared types for the freelist arbiter: FSM state encoding.
package freelist_arb_pkg;

    typedef enum logic [1:0] {
        ARB_RUN     = 2'd0,
        ARB_FLUSH   = 2'd1,
        ARB_RECOVER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/freelist_arb_rr_pick.sv
// Round-robin picker: selects the first K set bits of vec scanning from ptr
// with wrap, reporting each pick as one-hot plus index, and the next pointer.
module freelist_arb_rr_pick #(
    parameter int N  = 4,
    parameter int K  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]          vec,
    input  logic [PW-1:0]         ptr,
    output logic [K-1:0][N-1:0]   sel,
    output logic [K-1:0]          valid,
    output logic [K-1:0][PW-1:0]  idx,
    output logic [PW-1:0]         next_ptr
);

    int pos;
    int cnt;

    always_comb begin
        sel      = '0;
        valid    = '0;
        idx      = '0;
        next_ptr = ptr;
        pos      = 0;
        cnt      = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            if (vec[PW'(pos)] && cnt < K) begin
                for (int k = 0; k < K; k++) begin
                    if (k == cnt) begin
                        sel[k][PW'(pos)] = 1'b1;
                        valid[k]         = 1'b1;
                        idx[k]           = PW'(pos);
                    end
                end
                next_ptr = (pos == N - 1) ? '0 : PW'(pos + 1);
                cnt      = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/freelist_arb.sv
// Round-robin arbiter and flush sequencer in front of a scalar freelist:
// shares read ports for allocation, write ports for tag return.
module freelist_arb
    import freelist_arb_pkg::*;
#(
    parameter int REQ   = 4,
    parameter int READ  = 2,
    parameter int WRITE = 2,
    parameter int DEPTH = 16,
    parameter int TAG   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [REQ-1:0]            req,
    output logic [REQ-1:0]            gnt,
    output logic [REQ-1:0][TAG-1:0]   gnt_tag,
    input  logic [REQ-1:0]            ret_valid,
    input  logic [REQ-1:0][TAG-1:0]   ret_tag,
    output logic [REQ-1:0]            ret_ready,
    output logic [READ-1:0]           fl_re_,
    input  logic [READ-1:0][TAG-1:0]  fl_rd,
    input  logic [READ-1:0]           fl_v,
    input  logic                      fl_busy,
    output logic [WRITE-1:0]          fl_we_,
    output logic [WRITE-1:0][TAG-1:0] fl_wd,
    output logic                      fl_flush_,
    output logic [TAG:0]              out_cnt,
    output logic [1:0]                state_o
);

    localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;
    localparam int CW = TAG + 2;

    arb_state_t state, state_next;
    logic       run;

    logic [PW-1:0] gnt_ptr, gnt_ptr_next;
    logic [PW-1:0] ret_ptr, ret_ptr_next;

    logic [READ-1:0][REQ-1:0]  a_sel;
    logic [READ-1:0]           a_valid;
    logic [READ-1:0][PW-1:0]   a_idx;
    logic [PW-1:0]             a_next;
    logic [WRITE-1:0][REQ-1:0] r_sel;
    logic [WRITE-1:0]          r_valid;
    logic [WRITE-1:0][PW-1:0]  r_idx;
    logic [PW-1:0]             r_next;

    logic                    alloc_en, ret_en;
    logic [READ-1:0]         port_gnt;
    logic [WRITE-1:0]        port_ret;
    logic [REQ-1:0]          gnt_next;
    logic [REQ-1:0][TAG-1:0] tag_next;
    logic [CW-1:0]           n_gnt, n_ret, cnt_sum;
    logic [TAG:0]            cnt_next;

    always_ff @(posedge clk) begin
        if (reset) state <= ARB_RUN;
        else       state <= state_next;
    end

    // A flush arriving in FLUSH or RECOVER is deliberately dropped.
    always_comb begin
        state_next = state;
        case (state)
            ARB_RUN:     if (flush) state_next = ARB_FLUSH;
            ARB_FLUSH:   state_next = ARB_RECOVER;
            ARB_RECOVER: state_next = ARB_RUN;
            default:     state_next = ARB_RUN;
        endcase
    end

    always_comb begin
        run       = (state == ARB_RUN);
        fl_flush_ = (state != ARB_FLUSH);
        state_o   = state;
    end

    freelist_arb_rr_pick #(.N(REQ), .K(READ), .PW(PW)) u_alloc_pick (
        .vec      (req),
        .ptr      (gnt_ptr),
        .sel      (a_sel),
        .valid    (a_valid),
        .idx      (a_idx),
        .next_ptr (a_next)
    );

    freelist_arb_rr_pick #(.N(REQ), .K(WRITE), .PW(PW)) u_ret_pick (
        .vec      (ret_valid),
        .ptr      (ret_ptr),
        .sel      (r_sel),
        .valid    (r_valid),
        .idx      (r_idx),
        .next_ptr (r_next)
    );

    // Pick k is bound to read port k; a pick whose port has no tag is skipped,
    // so the pointer follows the last pick that actually got a tag.
    always_comb begin
        alloc_en     = run && !fl_busy && !flush;
        gnt_next     = '0;
        tag_next     = '0;
        gnt_ptr_next = gnt_ptr;
        n_gnt        = '0;
        for (int k = 0; k < READ; k++) begin
            port_gnt[k] = alloc_en && a_valid[k] && fl_v[k];
            fl_re_[k]   = !port_gnt[k];
            n_gnt       = n_gnt + CW'(port_gnt[k]);
            if (port_gnt[k]) begin
                gnt_ptr_next = (a_idx[k] == PW'(REQ - 1)) ? '0 : a_idx[k] + PW'(1);
                for (int r = 0; r < REQ; r++) begin
                    if (a_sel[k][r]) begin
                        gnt_next[r] = 1'b1;
                        tag_next[r] = fl_rd[k];
                    end
                end
            end
        end
    end

    always_comb begin
        ret_en       = run && !flush;
        ret_ready    = '0;
        ret_ptr_next = ret_ptr;
        n_ret        = '0;
        for (int j = 0; j < WRITE; j++) begin
            port_ret[j] = ret_en && r_valid[j];
            fl_we_[j]   = !port_ret[j];
            fl_wd[j]    = port_ret[j] ? ret_tag[r_idx[j]] : '0;
            n_ret       = n_ret + CW'(port_ret[j]);
            if (port_ret[j]) ret_ready = ret_ready | r_sel[j];
        end
        if (port_ret[0]) ret_ptr_next = r_next;
    end

    // Excess returns clamp the outstanding count at zero.
    always_comb begin
        cnt_sum  = CW'(out_cnt) + n_gnt;
        cnt_next = (cnt_sum < n_ret) ? '0 : (TAG + 1)'(cnt_sum - n_ret);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt     <= '0;
            gnt_tag <= '0;
            gnt_ptr <= '0;
            ret_ptr <= '0;
            out_cnt <= '0;
        end else begin
            gnt     <= gnt_next;
            gnt_tag <= tag_next;
            gnt_ptr <= gnt_ptr_next;
            ret_ptr <= ret_ptr_next;
            out_cnt <= (state == ARB_FLUSH) ? '0 : cnt_next;
        end
    end

endmodule

// File: tb/tb_freelist_arb.sv
// Directed bench for freelist_arb: vector table for allocation/return,
// hand sequences for flush timing and reset during recovery.
module tb_freelist_arb;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [15:0] gnt_tag;
    logic [3:0]  ret_valid;
    logic [15:0] ret_tag;
    logic [3:0]  ret_ready;
    logic [1:0]  fl_re_;
    logic [7:0]  fl_rd;
    logic [1:0]  fl_v;
    logic        fl_busy;
    logic [1:0]  fl_we_;
    logic [7:0]  fl_wd;
    logic        fl_flush_;
    logic [4:0]  out_cnt;
    logic [1:0]  state_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0] exp_q[$];

    freelist_arb #(.REQ(4), .READ(2), .WRITE(2), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req       (req),
        .gnt       (gnt),
        .gnt_tag   (gnt_tag),
        .ret_valid (ret_valid),
        .ret_tag   (ret_tag),
        .ret_ready (ret_ready),
        .fl_re_    (fl_re_),
        .fl_rd     (fl_rd),
        .fl_v      (fl_v),
        .fl_busy   (fl_busy),
        .fl_we_    (fl_we_),
        .fl_wd     (fl_wd),
        .fl_flush_ (fl_flush_),
        .out_cnt   (out_cnt),
        .state_o   (state_o)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  v;
        logic        busy;
        logic [3:0]  rv;
        logic [1:0]  re_;
        logic [3:0]  rdy;
        logic [1:0]  we_;
        logic [7:0]  wd;
        logic [3:0]  gnt;
        logic [15:0] tag;
        logic [4:0]  cnt;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [3:0] r, input logic [1:0] v, input logic b,
                         input logic [3:0] rv, input logic f);
        req       = r;
        fl_v      = v;
        fl_busy   = b;
        ret_valid = rv;
        flush     = f;
    endtask

    // Scoreboard: the expected registered grant is queued when the cycle is driven.
    task automatic check_gnt(input string name);
        logic [3:0] e;
        e = exp_q.pop_front();
        chk(name, 32'(gnt), 32'(e));
    endtask

    function automatic logic [15:0] tag_mask(input logic [3:0] g);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (g[i]) m[i*4 +: 4] = 4'hf;
        return m;
    endfunction

    initial begin
        // ret_tag {9,6,7,2}, fl_rd {5,3}
        ret_tag = 16'h9672;
        fl_rd   = 8'h53;
        reset   = 1'b1;
        drive(4'b0, 2'b0, 1'b0, 4'b0, 1'b0);

        tbl[0] = '{4'b1111, 2'b11, 1'b0, 4'b0000, 2'b00, 4'b0000, 2'b11, 8'h00, 4'b0011, 16'h0053, 5'd2};
        tbl[1] = '{4'b1111, 2'b11, 1'b0, 4'b0000, 2'b00, 4'b0000, 2'b11, 8'h00, 4'b1100, 16'h5300, 5'd4};
        tbl[2] = '{4'b0110, 2'b01, 1'b0, 4'b0000, 2'b10, 4'b0000, 2'b11, 8'h00, 4'b0010, 16'h0030, 5'd5};
        tbl[3] = '{4'b1111, 2'b11, 1'b1, 4'b0000, 2'b11, 4'b0000, 2'b11, 8'h00, 4'b0000, 16'h0000, 5'd5};
        tbl[4] = '{4'b0000, 2'b11, 1'b0, 4'b1011, 2'b11, 4'b0011, 2'b00, 8'h72, 4'b0000, 16'h0000, 5'd3};
        tbl[5] = '{4'b0000, 2'b11, 1'b0, 4'b1011, 2'b11, 4'b1001, 2'b00, 8'h29, 4'b0000, 16'h0000, 5'd1};
        tbl[6] = '{4'b0100, 2'b11, 1'b0, 4'b0100, 2'b10, 4'b0100, 2'b10, 8'h06, 4'b0100, 16'h0300, 5'd1};
        tbl[7] = '{4'b0000, 2'b11, 1'b0, 4'b1111, 2'b11, 4'b1001, 2'b00, 8'h29, 4'b0000, 16'h0000, 5'd0};
        tbl[8] = '{4'b1001, 2'b10, 1'b0, 4'b0000, 2'b01, 4'b0000, 2'b11, 8'h00, 4'b0001, 16'h0005, 5'd1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_gnt_tag", 32'(gnt_tag), 32'h0);
        chk("reset_out_cnt", 32'(out_cnt), 32'h0);
        chk("reset_state", 32'(state_o), 32'h0);
        chk("reset_fl_flush_", 32'(fl_flush_), 32'h1);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].req, tbl[i].v, tbl[i].busy, tbl[i].rv, 1'b0);
            exp_q.push_back(tbl[i].gnt);
            #2;
            chk($sformatf("v%0d_fl_re_", i), 32'(fl_re_), 32'(tbl[i].re_));
            chk($sformatf("v%0d_ret_ready", i), 32'(ret_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_fl_we_", i), 32'(fl_we_), 32'(tbl[i].we_));
            chk($sformatf("v%0d_fl_wd", i), 32'(fl_wd), 32'(tbl[i].wd));
            @(posedge clk); #1;
            check_gnt($sformatf("v%0d_gnt", i));
            chk($sformatf("v%0d_gnt_tag", i), 32'(gnt_tag & tag_mask(tbl[i].gnt)), 32'(tbl[i].tag));
            chk($sformatf("v%0d_out_cnt", i), 32'(out_cnt), 32'(tbl[i].cnt));
        end

        // Flush pulse with requests held high; gnt_ptr=1, out_cnt=1 here.
        drive(4'b1111, 2'b11, 1'b0, 4'b0000, 1'b1);
        #2;
        chk("fl_cyc_re_", 32'(fl_re_), 32'h3);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_t1_state", 32'(state_o), 32'h1);
        chk("fl_t1_flush_", 32'(fl_flush_), 32'h0);
        chk("fl_t1_gnt", 32'(gnt), 32'h0);
        #2;
        chk("fl_t1_re_", 32'(fl_re_), 32'h3);
        @(posedge clk); #1;
        chk("fl_t2_state", 32'(state_o), 32'h2);
        chk("fl_t2_flush_", 32'(fl_flush_), 32'h1);
        chk("fl_t2_gnt", 32'(gnt), 32'h0);
        chk("fl_t2_out_cnt", 32'(out_cnt), 32'h0);
        @(posedge clk); #1;
        chk("fl_t3_state", 32'(state_o), 32'h0);
        chk("fl_t3_gnt", 32'(gnt), 32'h0);
        @(posedge clk); #1;
        chk("fl_t4_gnt", 32'(gnt), 32'h6);
        chk("fl_t4_gnt_tag", 32'(gnt_tag & tag_mask(4'b0110)), 32'h0530);
        chk("fl_t4_out_cnt", 32'(out_cnt), 32'h2);

        // Reset asserted while in RECOVER.
        drive(4'b0000, 2'b11, 1'b0, 4'b0000, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_state", 32'(state_o), 32'h2);
        reset = 1'b1;
        drive(4'b1111, 2'b11, 1'b0, 4'b0000, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_tag", 32'(gnt_tag), 32'h0);
        chk("rst_out_cnt", 32'(out_cnt), 32'h0);
        chk("rst_fl_flush_", 32'(fl_flush_), 32'h1);
        ret_valid = 4'b1111;
        #2;
        chk("rst_ret_ready", 32'(ret_ready), 32'h3);
        @(posedge clk); #1;
        chk("rst_gnt_ptr0", 32'(gnt), 32'h3);
        chk("rst_cnt_after", 32'(out_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
